control_unit_fast: RTL and testbench
====================================

# control_unit_fast

Multicycle main control unit for the 16-bit CPU datapath. A one-hot Moore-style FSM sequences each instruction through fetch, decode and execute states. It drives every datapath write-enable and mux select from the current state and the 4-bit opcode. It sits between the instruction register (opcode source), the branch-condition logic (`Perform`), the load-multiple counter (`LMC`), and the datapath muxes and registers.

## Interface
No parameters.
- `CLK` input 1: system clock; state updates on the rising edge.
- `RESET` input 1: asynchronous, active-low reset.
- `Op` input 4: opcode from the instruction register.
- `Perform` input 1: branch condition is true.
- `LMC` input 1: load-multiple continue (more words remain).
- `PCW` output 1: PC write enable.
- `Jump` output 1: PC source select; 0 = ALU result, 1 = jump target.
- `MW` output 1: memory write enable.
- `LM` output 1: load-multiple step enable.
- `IW` output 1: instruction register write enable.
- `IorD` output 1: memory address select; 0 = PC, 1 = data address.
- `MSrc` output 1: memory write-data select; 0 = register B, 1 = PC.
- `RW` output 1: register file write enable.
- `RWSrc` output 3: register write-data select; 000 = ALU, 001 = memory data, 010 = load-multiple data, other codes reserved.
- `ALUOp` output 3: ALU function code; 000 = ADD.
- `SrcB` output 1: ALU B select; 0 = register B, 1 = constant 2.
- `FU` output 1: flag register update enable.
- `SPW` output 1: stack pointer write enable.
- `SPIorD` output 1: data address select; 0 = ALU/register address, 1 = SP.
- `s` output 9: current one-hot state, with bit k = state Sk.

## Operation
- Outputs are combinational from `s` and `Op`.
- Every output defaults to 0 (`RWSrc` = 000, `ALUOp` = 000) unless listed for a state below.
- States and the outputs each one asserts:
  - S1 FETCH: `IW`=1, `PCW`=1, `IorD`=0, `SrcB`=1, `ALUOp`=000. Next state is S2.
  - S2 DECODE: no outputs asserted. Next state is chosen by `Op`:
    - `Op` 0–7 (ALU ops) go to S3.
    - 8 (LOAD) and 13 (POP) go to S5.
    - 9 (STORE) and 12 (PUSH) go to S7.
    - 10 (BRANCH) goes to S8 if `Perform`=1, otherwise S1.
    - 11 (JUMP) goes to S8.
    - 14 (LOADM) goes to S9.
    - 15 (NOP) goes to S1.
  - S3 EXEC: `ALUOp`=`Op[2:0]`, `SrcB`=0, `FU`=1. Next state is S4.
  - S4 ALUWB: `RW`=1, `RWSrc`=000. Next state is S1.
  - S5 MEMRD: `IorD`=1. When `Op`=13, also `SPIorD`=1 and `SPW`=1 (SP post-increment). Next state is S6.
  - S6 LOADWB: `RW`=1, `RWSrc`=001. Next state is S1.
  - S7 STORE: `IorD`=1, `MW`=1, `MSrc`=0. When `Op`=12, also `SPIorD`=1 and `SPW`=1 (SP pre-decrement). Next state is S1.
  - S8 PCLOAD: `PCW`=1. `Jump`=1 when `Op`=11, otherwise 0 (branch uses the ALU target computed in S2). Next state is S1.
  - S9 LOADM: `LM`=1, `IorD`=1, `RW`=1, `RWSrc`=010. Stays in S9 while `LMC`=1; goes to S1 when `LMC`=0.
- Illegal state (`s` not one-hot): all outputs at their defaults, and the next state is S1.
- `Op` is sampled only in S2 for the transition. `Op` is also used combinationally in S3, S5, S7 and S8 and must remain stable through the instruction.

## Timing
- `RESET`=0 forces `s` = 9'b000000001 (S1) immediately, with no clock edge required.
- Outputs during reset equal the S1 outputs.
- The first rising edge after `RESET` rises moves the FSM to S2.
- Cycle counts per instruction, including fetch:
  - ALU: 4 cycles.
  - LOAD/POP: 4 cycles.
  - STORE/PUSH: 3 cycles.
  - JUMP: 3 cycles.
  - BRANCH taken: 3 cycles; not taken: 2 cycles.
  - NOP: 2 cycles.
  - LOADM: 3 + n cycles, where n = cycles with `LMC`=1 in S9.
- Reset asserted mid-instruction aborts the instruction immediately and returns the FSM to S1.

## Test plan
- Reset then ALU op: assert `RESET`=0 then release with `Op`=3. Required sequence: `s`=1 with `IW`=`PCW`=1; then `s`=2; then `s`=4 with `ALUOp`=011 and `FU`=1; then `s`=8 with `RW`=1 and `RWSrc`=000; then `s`=1.
- LOAD vs POP: `Op`=8 gives `s` 1, 2, 16 (`IorD`=1, `SPW`=0), 32 (`RWSrc`=001), 1. `Op`=13 gives the same sequence but with `SPIorD`=`SPW`=1 in `s`=16.
- STORE vs PUSH: `Op`=9 gives `s` 1, 2, 64 (`MW`=1, `SPIorD`=0), 1. `Op`=12 gives the same sequence but with `SPW`=`SPIorD`=1 in `s`=64.
- Branch and jump:
  - `Op`=10, `Perform`=0: `s` goes 1, 2, 1.
  - `Op`=10, `Perform`=1: `s` goes 1, 2, 128 (`PCW`=1, `Jump`=0), 1.
  - `Op`=11: reaches `s`=128 with `Jump`=1.
- LOADM: `Op`=14 with `LMC`=1 for 3 edges, then `LMC`=0. Required: `s`=256 holds for 4 cycles with `LM`=`RW`=1 and `RWSrc`=010, then returns to 1.
- All 64 combinations of `Op`/`Perform`/`LMC`: reset, then 5 clocks each. Every transition must match the table above, and `RESET` pulsed low mid-S3 must return `s` to 1 asynchronously.

Source files
------------

// File: rtl/control_unit_fast.sv
// control_unit_fast: one-hot multicycle control FSM driving datapath enables and selects
// from the current state and opcode.
module control_unit_fast (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] Op,
   input  logic       Perform,
   input  logic       LMC,
   output logic       PCW,
   output logic       Jump,
   output logic       MW,
   output logic       LM,
   output logic       IW,
   output logic       IorD,
   output logic       MSrc,
   output logic       RW,
   output logic [2:0] RWSrc,
   output logic [2:0] ALUOp,
   output logic       SrcB,
   output logic       FU,
   output logic       SPW,
   output logic       SPIorD,
   output logic [8:0] s
);
   typedef enum logic [8:0] {
      S1 = 9'h001, S2 = 9'h002, S3 = 9'h004, S4 = 9'h008, S5 = 9'h010,
      S6 = 9'h020, S7 = 9'h040, S8 = 9'h080, S9 = 9'h100
   } state_t;

   state_t s_q, s_d;

   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) s_q <= S1;
      else        s_q <= s_d;

   assign s = s_q;

   always_comb begin
      s_d    = S1;
      PCW    = 1'b0;
      Jump   = 1'b0;
      MW     = 1'b0;
      LM     = 1'b0;
      IW     = 1'b0;
      IorD   = 1'b0;
      MSrc   = 1'b0;
      RW     = 1'b0;
      RWSrc  = 3'b000;
      ALUOp  = 3'b000;
      SrcB   = 1'b0;
      FU     = 1'b0;
      SPW    = 1'b0;
      SPIorD = 1'b0;
      case (s_q)
         S1: begin
            IW   = 1'b1;
            PCW  = 1'b1;
            SrcB = 1'b1;
            s_d  = S2;
         end
         S2: s_d = (Op < 4'd8)                 ? S3 :
                   (Op == 4'd8  || Op == 4'd13) ? S5 :
                   (Op == 4'd9  || Op == 4'd12) ? S7 :
                   (Op == 4'd10)                ? (Perform ? S8 : S1) :
                   (Op == 4'd11)                ? S8 :
                   (Op == 4'd14)                ? S9 : S1;
         S3: begin
            ALUOp = Op[2:0];
            FU    = 1'b1;
            s_d   = S4;
         end
         S4: begin
            RW  = 1'b1;
            s_d = S1;
         end
         S5: begin
            IorD   = 1'b1;
            SPIorD = (Op == 4'd13);
            SPW    = (Op == 4'd13);
            s_d    = S6;
         end
         S6: begin
            RW    = 1'b1;
            RWSrc = 3'b001;
            s_d   = S1;
         end
         S7: begin
            IorD   = 1'b1;
            MW     = 1'b1;
            SPIorD = (Op == 4'd12);
            SPW    = (Op == 4'd12);
            s_d    = S1;
         end
         S8: begin
            PCW  = 1'b1;
            Jump = (Op == 4'd11);
            s_d  = S1;
         end
         S9: begin
            LM    = 1'b1;
            IorD  = 1'b1;
            RW    = 1'b1;
            RWSrc = 3'b010;
            s_d   = LMC ? S9 : S1;
         end
         default: s_d = S1;
      endcase
   end
endmodule

// File: tb/tb_control_unit_fast.sv
// tb_control_unit_fast: directed and randomized checks of control_unit_fast against
// a state-number reference model built from the instruction sequencing rules.
module tb_control_unit_fast;
   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [3:0] Op = 4'd0;
   logic       Perform = 1'b0;
   logic       LMC = 1'b0;
   logic       PCW, Jump, MW, LM, IW, IorD, MSrc, RW, SrcB, FU, SPW, SPIorD;
   logic [2:0] RWSrc, ALUOp;
   logic [8:0] s;

   int passed = 0;
   int total  = 0;
   int st     = 1;

   control_unit_fast dut (
      .CLK(CLK), .RESET(RESET), .Op(Op), .Perform(Perform), .LMC(LMC),
      .PCW(PCW), .Jump(Jump), .MW(MW), .LM(LM), .IW(IW), .IorD(IorD),
      .MSrc(MSrc), .RW(RW), .RWSrc(RWSrc), .ALUOp(ALUOp), .SrcB(SrcB),
      .FU(FU), .SPW(SPW), .SPIorD(SPIorD), .s(s)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       pcw, jump, mw, lm, iw, iord, msrc, rw;
      logic [2:0] rwsrc, aluop;
      logic       srcb, fu, spw, spiord;
   } outs_t;

   // Next step number (1..9) from the instruction flow: fetch, decode, then class-specific path.
   function automatic int model_next(int cur, int op, bit perf, bit lmc);
      case (cur)
         2: begin
            if (op <= 7)                   return 3;
            if (op == 8 || op == 13)       return 5;
            if (op == 9 || op == 12)       return 7;
            if (op == 10)                  return perf ? 8 : 1;
            if (op == 11)                  return 8;
            if (op == 14)                  return 9;
            return 1;
         end
         1:       return 2;
         3:       return 4;
         5:       return 6;
         9:       return lmc ? 9 : 1;
         default: return 1;
      endcase
   endfunction

   function automatic outs_t model_outs(int cur, int op);
      outs_t o = '0;
      bit pop  = (op == 13);
      bit push = (op == 12);
      if (cur == 1) begin o.iw = 1; o.pcw = 1; o.srcb = 1; end
      if (cur == 3) begin o.aluop = 3'(op % 8); o.fu = 1; end
      if (cur == 4) o.rw = 1;
      if (cur == 5) begin o.iord = 1; o.spiord = pop; o.spw = pop; end
      if (cur == 6) begin o.rw = 1; o.rwsrc = 3'd1; end
      if (cur == 7) begin o.iord = 1; o.mw = 1; o.spiord = push; o.spw = push; end
      if (cur == 8) begin o.pcw = 1; o.jump = (op == 11); end
      if (cur == 9) begin o.lm = 1; o.iord = 1; o.rw = 1; o.rwsrc = 3'd2; end
      return o;
   endfunction

   task automatic check(input string tag);
      outs_t got, exp;
      logic [8:0] exp_s;
      got   = '{PCW, Jump, MW, LM, IW, IorD, MSrc, RW, RWSrc, ALUOp, SrcB, FU, SPW, SPIorD};
      exp   = model_outs(st, int'(Op));
      exp_s = 9'(1 << (st - 1));
      total++;
      assert (s === exp_s) passed++;
      else $error("FAIL %s state: got %h expected %h (op=%0d)", tag, s, exp_s, Op);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s outputs: got %h expected %h (state=%0d op=%0d)", tag, got, exp, st, Op);
   endtask

   task automatic do_reset(input string tag);
      @(negedge CLK);
      RESET = 1'b0;
      st = 1;
      #1 check({tag, "_in_reset"});
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   task automatic step(input string tag, input bit pulse_s3);
      @(posedge CLK);
      st = model_next(st, int'(Op), Perform, LMC);
      #1 check(tag);
      if (pulse_s3 && st == 3) begin
         #1 RESET = 1'b0;
         st = 1;
         #1 check({tag, "_async_rst"});
         #1 RESET = 1'b1;
      end
   endtask

   initial begin
      do_reset("rst_alu");
      Op = 4'd3;
      repeat (4) step("alu", 1'b0);
      Op = 4'd8;  repeat (4) step("load", 1'b0);
      Op = 4'd13; repeat (4) step("pop", 1'b0);
      Op = 4'd9;  repeat (3) step("store", 1'b0);
      Op = 4'd12; repeat (3) step("push", 1'b0);
      Op = 4'd10; Perform = 1'b0; repeat (2) step("br_nt", 1'b0);
      Perform = 1'b1; repeat (3) step("br_t", 1'b0);
      Op = 4'd11; Perform = 1'b0; repeat (3) step("jump", 1'b0);
      Op = 4'd15; repeat (2) step("nop", 1'b0);
      Op = 4'd14; LMC = 1'b1;
      repeat (5) step("loadm_run", 1'b0);
      LMC = 1'b0;
      step("loadm_end", 1'b0);
      step("after_loadm", 1'b0);

      for (int c = 0; c < 64; c++) begin
         Op = 4'(c >> 2); Perform = c[1]; LMC = c[0];
         do_reset("combo");
         repeat (5) step("combo", 1'b1);
      end

      do_reset("rand");
      for (int i = 0; i < 600; i++) begin
         Perform = 1'($urandom);
         LMC = ($urandom_range(0, 3) != 0);
         if (st == 1) Op = 4'($urandom);
         step("rand", ($urandom_range(0, 7) == 0));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
